// File: rtl/pc_gen.sv
// Program-counter generator: BOOT/RUN/HALT fetch control with trap > redirect > sequential priority.
// PC/state changes show up one cycle after the input. A pending request holds its PC until fire, trap or redirect.
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(4),
    parameter int              ALIGN_BITS   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    input  logic            halt_req,
    input  logic            resume,
    input  logic            fetch_ready,
    output logic            fetch_valid,
    output logic [XLEN-1:0] fetch_pc,
    output logic            halted,
    output logic            misalign_err,
    output logic [XLEN-1:0] bad_addr
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    localparam logic [XLEN-1:0] STEP       = XLEN'(1) << ALIGN_BITS;
    localparam logic [XLEN-1:0] ALIGN_MASK = STEP - XLEN'(1);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] bad_addr_q, bad_addr_d;
    logic            fire;
    logic            target_misaligned;

    assign fire              = (state_q == RUN) && fetch_ready && !stall;
    assign target_misaligned = |(redirect_target & ALIGN_MASK);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (halt_req) state_d = HALT;
            HALT:    if (resume && !halt_req) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // Trap and redirect bypass stall/ready and may replace an unaccepted request.
    always_comb begin
        pc_d       = pc_q;
        misalign_d = 1'b0;
        bad_addr_d = bad_addr_q;
        if (trap_valid) begin
            pc_d = trap_target & ~ALIGN_MASK;
        end else if (redirect_valid && !target_misaligned) begin
            pc_d = redirect_target;
        end else if (redirect_valid) begin
            pc_d       = TRAP_VECTOR;
            misalign_d = 1'b1;
            bad_addr_d = redirect_target;
        end else if (fire) begin
            pc_d = pc_q + STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            misalign_q <= 1'b0;
            bad_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            bad_addr_q <= bad_addr_d;
        end
    end

    assign fetch_valid  = (state_q == RUN);
    assign halted       = (state_q == HALT);
    assign fetch_pc     = pc_q;
    assign misalign_err = misalign_q;
    assign bad_addr     = bad_addr_q;

endmodule
